// File: rtl/ox_board_collect.sv
// Serial board collector for the tic-tac-toe line counter: nine cell beats -> packed Sequence/Original_pos.
// Optional legality checker enabled by defining OX_BOARD_COLLECT_CHECK_EN.
module ox_board_collect #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_cell,
  input  logic [3:0] in_start,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [8:0] Sequence,
  output logic [3:0] Original_pos,
  output logic       out_abort,
  output logic       out_err
);

  localparam int unsigned IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] IDLE_LAST = (TIMEOUT > 0) ? IW'(TIMEOUT - 1) : '0;
  localparam logic [IW-1:0] IDLE_MAX  = IW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;

  state_t        state, state_nx;
  logic          accept, done, expire, timeout_hit;
  logic [3:0]    count;
  logic [IW-1:0] idle_cnt;

  assign timeout_hit = (TIMEOUT != 0) && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b1;
    out_valid = 1'b0;
    accept    = 1'b0;
    done      = 1'b0;
    expire    = 1'b0;
    case (state)
      IDLE: begin
        accept = in_valid;
        if (accept) state_nx = LOAD;
      end
      LOAD: begin
        accept = in_valid;
        if (accept && count == 4'd8) begin
          done     = 1'b1;
          state_nx = HOLD;
        end else if (!accept && timeout_hit) begin
          // idle counter would reach TIMEOUT at this edge: drop the board now
          expire   = 1'b1;
          state_nx = IDLE;
        end
      end
      HOLD: begin
        in_ready  = 1'b0;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || state != LOAD || accept) idle_cnt <= '0;
    else if (TIMEOUT != 0 && idle_cnt != IDLE_MAX) idle_cnt <= idle_cnt + IW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Sequence     <= '0;
      Original_pos <= '0;
      count        <= '0;
      out_abort    <= 1'b0;
    end else begin
      out_abort <= expire;
      if (state == IDLE && accept) begin
        Sequence     <= {8'b0, in_cell};
        Original_pos <= in_start;
        count        <= 4'd1;
      end else if (state == LOAD && accept) begin
        Sequence <= {Sequence[7:0], in_cell};
        count    <= count + 4'd1;
      end else if (expire) begin
        Sequence     <= '0;
        Original_pos <= '0;
        count        <= '0;
      end else if (state == HOLD && out_ready) begin
        count <= '0;
      end
    end
  end

`ifdef OX_BOARD_COLLECT_CHECK_EN
  logic [3:0] xcnt, xfinal;
  logic       err_q;

  assign xfinal  = xcnt + {3'b0, in_cell};
  assign out_err = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      xcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && accept)      xcnt <= {3'b0, in_cell};
      else if (state == LOAD && accept) xcnt <= xfinal;
      if (done)
        err_q <= (Original_pos == 4'd0) || (Original_pos > 4'd9) ||
                 !((xfinal == 4'd4) || (xfinal == 4'd5));
      else if (state == HOLD && out_ready)
        err_q <= 1'b0;
    end
  end
`else
  assign out_err = 1'b0;
`endif

endmodule

// File: tb/tb_ox_board_collect.sv
// Self-checking bench for ox_board_collect: vector table, directed corner sequences, random stimulus vs. a queue-based model.
module tb_ox_board_collect;
  localparam int unsigned TO = 15;

  logic       clk = 1'b0;
  logic       rst, in_valid, in_cell, out_ready;
  logic [3:0] in_start;
  logic       in_ready, out_valid, out_abort, out_err;
  logic [8:0] Sequence;
  logic [3:0] Original_pos;

  int tests = 0;
  int fails = 0;

  ox_board_collect #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_cell(in_cell), .in_start(in_start), .out_valid(out_valid),
    .out_ready(out_ready), .Sequence(Sequence), .Original_pos(Original_pos),
    .out_abort(out_abort), .out_err(out_err)
  );

  always #5 clk = ~clk;

  // reference model: a board is a queue of received cells
  bit         m_hold, m_abort, m_err;
  logic [8:0] m_seq;
  logic [3:0] m_pos;
  bit         m_cells[$];
  int         m_gap;

  task automatic model_step(input bit r, input bit v, input bit c, input logic [3:0] s, input bit o);
    int xs;
    m_abort = 1'b0;
    if (r) begin
      m_hold = 0; m_err = 0; m_seq = '0; m_pos = '0; m_gap = 0;
      m_cells.delete();
    end else if (m_hold) begin
      if (o) begin m_hold = 0; m_err = 0; end
    end else if (v) begin
      if (m_cells.size() == 0) m_pos = s;
      m_cells.push_back(c);
      m_gap = 0;
      if (m_cells.size() == 9) begin
        m_seq = '0;
        xs = 0;
        foreach (m_cells[i]) begin
          m_seq = {m_seq[7:0], m_cells[i]};
          xs += int'(m_cells[i]);
        end
`ifdef OX_BOARD_COLLECT_CHECK_EN
        m_err = (m_pos < 1 || m_pos > 9) || !(xs == 4 || xs == 5);
`else
        m_err = 0;
`endif
        m_hold = 1;
        m_cells.delete();
      end
    end else if (m_cells.size() > 0 && TO > 0) begin
      m_gap++;
      if (m_gap == int'(TO)) begin
        m_abort = 1;
        m_gap = 0;
        m_cells.delete();
      end
    end
  endtask

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", n, act, exp, $time);
    end
  endtask

  // one clock: drive, take the edge, update model, compare
  task automatic cycle(input bit r, input bit v, input bit c, input logic [3:0] s, input bit o);
    rst = r; in_valid = v; in_cell = c; in_start = s; out_ready = o;
    @(posedge clk); #1;
    model_step(r, v, c, s, o);
    chk("in_ready", 32'(in_ready), 32'(!m_hold));
    chk("out_valid", 32'(out_valid), 32'(m_hold));
    chk("out_abort", 32'(out_abort), 32'(m_abort));
    chk("out_err", 32'(out_err), 32'(m_hold ? m_err : 1'b0));
    if (m_hold) begin
      chk("Sequence", 32'(Sequence), 32'(m_seq));
      chk("Original_pos", 32'(Original_pos), 32'(m_pos));
    end
    if (r) begin
      chk("rst_Sequence", 32'(Sequence), 32'd0);
      chk("rst_Original_pos", 32'(Original_pos), 32'd0);
    end
  endtask

  task automatic send_board(input logic [3:0] s, input logic [8:0] b, input int gap);
    logic [8:0] bits;
    bits = b;
    for (int i = 8; i >= 0; i--) begin
      cycle(0, 1, bits[i], s, 0);
      if (i != 0) for (int g = 0; g < gap; g++) cycle(0, 0, 0, 4'hA, 0);
    end
  endtask

  task automatic expect_board(input string n, input logic [8:0] sq, input logic [3:0] p, input bit e);
    chk({n, "_valid"}, 32'(out_valid), 32'd1);
    chk({n, "_seq"}, 32'(Sequence), 32'(sq));
    chk({n, "_pos"}, 32'(Original_pos), 32'(p));
`ifdef OX_BOARD_COLLECT_CHECK_EN
    chk({n, "_err"}, 32'(out_err), 32'(e));
`else
    chk({n, "_err"}, 32'(out_err), 32'd0);
`endif
  endtask

  typedef struct {
    bit r, v, c; logic [3:0] s; bit o;
    bit e_rdy, e_vld, chk_data;
    logic [8:0] e_seq; logic [3:0] e_pos;
  } vec_t;

  vec_t tbl[12];

  initial begin
    #2ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit mode;
    tbl[0]  = '{1, 0, 0, 4'h0, 0, 1, 0, 1, 9'h000, 4'h0};
    tbl[1]  = '{0, 1, 0, 4'h1, 0, 1, 0, 0, 9'h000, 4'h0};
    tbl[2]  = '{0, 1, 0, 4'hF, 0, 1, 0, 0, 9'h000, 4'h0};
    tbl[3]  = '{0, 1, 0, 4'hF, 0, 1, 0, 0, 9'h000, 4'h0};
    tbl[4]  = '{0, 1, 1, 4'hF, 0, 1, 0, 0, 9'h000, 4'h0};
    tbl[5]  = '{0, 1, 1, 4'hF, 0, 1, 0, 0, 9'h000, 4'h0};
    tbl[6]  = '{0, 1, 0, 4'hF, 0, 1, 0, 0, 9'h000, 4'h0};
    tbl[7]  = '{0, 1, 1, 4'hF, 0, 1, 0, 0, 9'h000, 4'h0};
    tbl[8]  = '{0, 1, 0, 4'hF, 0, 1, 0, 0, 9'h000, 4'h0};
    tbl[9]  = '{0, 1, 1, 4'hF, 0, 0, 1, 1, 9'b000110101, 4'h1};
    tbl[10] = '{0, 1, 1, 4'h7, 0, 0, 1, 1, 9'b000110101, 4'h1};
    tbl[11] = '{0, 1, 0, 4'h7, 1, 1, 0, 0, 9'h000, 4'h0};

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].r, tbl[i].v, tbl[i].c, tbl[i].s, tbl[i].o);
      chk("tbl_rdy", 32'(in_ready), 32'(tbl[i].e_rdy));
      chk("tbl_vld", 32'(out_valid), 32'(tbl[i].e_vld));
      if (tbl[i].chk_data) begin
        chk("tbl_seq", 32'(Sequence), 32'(tbl[i].e_seq));
        chk("tbl_pos", 32'(Original_pos), 32'(tbl[i].e_pos));
      end
    end

    // beat offered during out_ready cycle must not have started a board
    send_board(4'h2, 9'b110010011, 0);
    expect_board("after_hold", 9'b110010011, 4'h2, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 1, i[0], 4'h9, 0);
      chk("hold_ignore_seq", 32'(Sequence), 32'b110010011);
    end
    cycle(0, 0, 0, 0, 1);

    // gapped input
    send_board(4'h5, 9'b000110101, 3);
    expect_board("gapped", 9'b000110101, 4'h5, 0);
    cycle(0, 0, 0, 0, 1);

    // timeout: 4 beats then 16 idle cycles, abort exactly 16 cycles after the 4th beat
    for (int i = 0; i < 4; i++) cycle(0, 1, 1, 4'h8, 0);
    for (int k = 1; k <= 16; k++) begin
      cycle(0, 0, 0, 0, 0);
      chk("abort_pulse", 32'(out_abort), 32'(k == 15));
    end
    send_board(4'h4, 9'b101010100, 0);
    expect_board("after_abort", 9'b101010100, 4'h4, 0);
    cycle(0, 0, 0, 0, 1);

    // beat arriving on the last idle cycle before expiry keeps the board
    for (int i = 0; i < 3; i++) cycle(0, 1, 0, 4'h6, 0);
    for (int k = 0; k < int'(TO) - 1; k++) cycle(0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) cycle(0, 1, 1, 4'h0, 0);
    expect_board("late_beat", 9'b000111111, 4'h6, 1);
    cycle(0, 0, 0, 0, 1);

    // reset mid-load
    for (int i = 0; i < 6; i++) cycle(0, 1, 1, 4'h3, 0);
    cycle(1, 0, 0, 0, 0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_valid", 32'(out_valid), 32'd0);
    send_board(4'h9, 9'b011001100, 0);
    expect_board("after_rst", 9'b011001100, 4'h9, 0);
    cycle(0, 0, 0, 0, 1);

    // legality checker boards
    send_board(4'h3, 9'b111111111, 0);
    expect_board("all_x", 9'b111111111, 4'h3, 1);
    cycle(0, 0, 0, 0, 1);
    send_board(4'h3, 9'b100101100, 0);
    expect_board("four_x", 9'b100101100, 4'h3, 0);
    cycle(0, 0, 0, 0, 1);
    send_board(4'h0, 9'b100101100, 0);
    expect_board("pos_zero", 9'b100101100, 4'h0, 1);
    cycle(0, 0, 0, 0, 1);

    // randomized stimulus with dense and sparse phases
    mode = 0;
    for (int n = 0; n < 5000; n++) begin
      if (n % 250 == 0) mode = ~mode;
      cycle($urandom_range(0, 299) == 0,
            mode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 19) == 0),
            1'($urandom), 4'($urandom), $urandom_range(0, 2) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ox_board_collect.md
# ox_board_collect

Serial front end for the tic-tac-toe line counter. It accepts one board cell per handshake beat, plus a start position on the first beat. After nine accepted cells it presents the packed 9-bit `Sequence` and `Original_pos` to the line counter, and holds them until the consumer takes them. It also drops boards whose input stream stalls for too long.

## Interface
- `TIMEOUT`, default 15: idle cycles allowed between accepted beats while loading before the board is dropped; 0 disables the timeout.
- `clk` input 1: single clock; all logic is on its rising edge.
- `rst` input 1: synchronous reset, active-high.
- `in_valid` input 1: the cell beat on `in_cell` is valid this cycle.
- `in_ready` output 1: the block accepts a beat this cycle.
- `in_cell` input 1: cell mark; 0 = O, 1 = X.
- `in_start` input 4: start position; sampled only on the first beat of a board.
- `out_valid` output 1: `Sequence`/`Original_pos` hold a complete board.
- `out_ready` input 1: the consumer takes the board this cycle.
- `Sequence` output 9: packed board; the first received cell sits in bit 8, the ninth in bit 0.
- `Original_pos` output 4: the captured `in_start`.
- `out_abort` output 1: one-cycle pulse when a partial board is dropped on timeout.
- `out_err` output 1: board-legality flag, qualified by `out_valid` (see Configuration).

## Operation
- States:
  - IDLE: no board in progress.
  - LOAD: cells 1..8 accepted, waiting for more.
  - HOLD: a complete board is presented.
- A beat is accepted when `in_valid && in_ready`.
- `in_ready` = 1 in IDLE and LOAD, 0 in HOLD.
- IDLE:
  - On an accepted beat: capture `in_start` into `Original_pos`, shift the cell in, set count = 1, go to LOAD.
- LOAD:
  - Each accepted beat shifts the shift register left by one, with the new cell entering at bit 0, and increments count.
  - The beat that makes count = 9 moves the state to HOLD.
  - `in_start` is ignored on beats 2..9.
- HOLD:
  - `out_valid` = 1.
  - `Sequence`, `Original_pos` and `out_err` are stable.
  - On `out_ready` = 1, go to IDLE.
- Timeout, LOAD only, when `TIMEOUT` > 0:
  - The idle counter clears on every accepted beat and increments on every other LOAD cycle.
  - When it reaches `TIMEOUT`: go to IDLE, pulse `out_abort` for one cycle, and discard the partial board.
  - The idle counter width is clog2(`TIMEOUT`+1); it saturates and never wraps.
- `in_start` values 0 or 10..15 are captured as given; no correction is applied.
- The count is 4 bits and never exceeds 9.

## Timing
- Reset values:
  - State = IDLE.
  - `in_ready` = 1.
  - `out_valid` = 0.
  - `Sequence` = 0.
  - `Original_pos` = 0.
  - `out_abort` = 0.
  - `out_err` = 0.
  - count = 0 and the idle counter = 0.
- Reset mid-LOAD or mid-HOLD discards the board; the reset values hold on the cycle after `rst` is sampled high.
- Latency: with the ninth beat accepted in cycle N, `out_valid` = 1 in cycle N+1.
- Minimum board period: 9 accept cycles + 1 HOLD cycle. Back-to-back boards are possible only with `out_ready` held at 1.
- In HOLD, `in_valid` is ignored: no capture, no state change. This includes the cycle where `out_ready` = 1; the next board's first beat is accepted no earlier than the following IDLE cycle.
- Timeout example (`TIMEOUT` = 15): the last accepted beat is in cycle N, with no beats after it. The counter reaches 15 at the end of cycle N+15. `out_abort` is high in cycle N+16, and the state is IDLE from cycle N+16.
- A beat accepted in the same cycle the counter would reach `TIMEOUT` wins: no abort, the counter clears.
- `out_abort` and `out_valid` are never high together.

## Configuration
- Macro: `OX_BOARD_COLLECT_CHECK_EN`.
- Defined:
  - While loading, the block counts X cells (`in_cell` = 1).
  - On entry to HOLD, `out_err` = 1 if `Original_pos` is outside 1..9, or if the X count is not 4 or 5 (O count = 9 − X count).
  - `out_err` is registered together with `out_valid` and clears on leaving HOLD.
- Undefined: the X counter and checker are not built; `out_err` is tied to 0.

## Test plan
- Basic load:
  - Stimulus: reset, then 9 consecutive beats with `in_start` = 1 and cells 0,0,0,1,1,0,1,0,1, with `out_ready` = 0.
  - Response: `out_valid` rises one cycle after the ninth beat; `Sequence` = 9'b000110101, `Original_pos` = 1, `in_ready` = 0; held until `out_ready` = 1, then IDLE and `in_ready` = 1 the next cycle.
- Gapped input:
  - Stimulus: `in_start` = 5, same cells as basic load, with 3-cycle gaps between beats, `TIMEOUT` = 15.
  - Response: the same `Sequence`, `Original_pos` = 5, no `out_abort`.
- Timeout:
  - Stimulus: 4 beats, then 16 idle cycles.
  - Response: `out_abort` is a single-cycle pulse exactly 16 cycles after the fourth beat. A following 9-beat board is packed correctly, with no residue from the dropped board.
- HOLD ignore:
  - Stimulus: in HOLD, drive `in_valid` = 1 with varying cells and `out_ready` = 1 for one cycle.
  - Response: `Sequence` is unchanged while HOLD lasts; the beat in the `out_ready` cycle is not captured.
- Reset mid-load:
  - Stimulus: assert `rst` after 6 beats.
  - Response: all outputs return to their reset values on the next cycle; a following full board is packed correctly.
- With `OX_BOARD_COLLECT_CHECK_EN`:
  - Board of all X with `in_start` = 3 → `out_err` = 1.
  - Board with 4 X and `in_start` = 3 → `out_err` = 0.
  - Board with 4 X and `in_start` = 0 → `out_err` = 1.
